// File: rtl/maxpool2x2_stream.sv
// -----------------------------------------------------------------------------
// maxpool2x2_stream
//
// Streaming 2x2 / stride-2 max-pool stage. Consumes a DIM x DIM map of unsigned
// DW-bit samples in raster order and emits the (DIM/2) x (DIM/2) pooled map in
// raster order. Only a half-row line buffer is kept, never the full input map.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous reset, active low
//   start      one-cycle pulse, arms one frame when idle (ignored otherwise)
//   in_valid   upstream sample valid
//   in_data    input sample, raster order
//   in_ready   sample accepted when in_valid && in_ready
//   out_valid  pooled sample valid (single-entry output register)
//   out_data   pooled maximum, stable while stalled
//   out_ready  downstream accepts out_data
//   busy       high from frame arm until the done cycle ends
//   done       one-cycle pulse after the final pooled sample is accepted
// -----------------------------------------------------------------------------
module maxpool2x2_stream #(
    parameter int DIM = 26,
    parameter int DW  = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int HALF = DIM / 2;
    localparam int CW   = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DIM - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Unsigned maximum; ties return either operand, which carry the same value.
    function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [DW-1:0] linebuf_q [HALF];

    logic          accept_s;
    logic          out_hs_s;
    logic [LW-1:0] lb_idx_s;
    logic [DW-1:0] lb_rd_s;
    logic [DW-1:0] hmax_s;
    logic [DW-1:0] vmax_s;
    logic          lb_we_s;

    // in_ready depends only on registered state and out_ready, so it can never
    // form a combinational loop with the upstream valid.
    assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_hs_s  = out_valid_q && out_ready;

    // Line buffer slot is shared by each horizontal pair of columns.
    assign lb_idx_s  = LW'(col_q >> 1);
    assign lb_rd_s   = linebuf_q[lb_idx_s];
    assign hmax_s    = umax(hold_q, in_data);
    assign vmax_s    = umax(lb_rd_s, hmax_s);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state, counter, pairing and output-register logic.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        lb_we_s     = 1'b0;

        // A completed handshake empties the output register; a result loaded
        // later in this block overrides the clear.
        if (out_hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    col_d   = {CW{1'b0}};
                    row_d   = {CW{1'b0}};
                    hold_d  = {DW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (accept_s) begin
                    if (!col_q[0]) begin
                        hold_d = in_data;
                    end else if (!row_q[0]) begin
                        lb_we_s = 1'b1;
                    end else begin
                        // Bottom-right pixel of a 2x2 window completes a result.
                        out_data_d  = vmax_s;
                        out_valid_d = 1'b1;
                    end

                    if (col_q == LAST_IDX) begin
                        col_d = {CW{1'b0}};
                        if (row_q == LAST_IDX) begin
                            state_d = ST_DRAIN;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_DRAIN: begin
                if (out_hs_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            col_q       <= {CW{1'b0}};
            row_q       <= {CW{1'b0}};
            hold_q      <= {DW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Half-row line buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            linebuf_q[lb_idx_s] <= hmax_s;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
module tb_maxpool2x2_stream;

    localparam int DIM  = 26;
    localparam int DW   = 20;
    localparam int NPIX = DIM * DIM;
    localparam int NOUT = (DIM / 2) * (DIM / 2);
    localparam int BUDGET = 5000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          done;

    maxpool2x2_stream #(.DIM(DIM), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] pix [NPIX];
    logic [DW-1:0] got [$];
    int            done_cnt;
    int            done_cyc;
    int            last_hs_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: direct max over each 2x2 window of the stored input frame.
    function automatic logic [DW-1:0] ref_out(input int k);
        int r, c;
        logic [DW-1:0] m;
        r = k / (DIM / 2);
        c = k % (DIM / 2);
        m = pix[(2 * r) * DIM + 2 * c];
        if (pix[(2 * r) * DIM + 2 * c + 1] > m) m = pix[(2 * r) * DIM + 2 * c + 1];
        if (pix[(2 * r + 1) * DIM + 2 * c] > m) m = pix[(2 * r + 1) * DIM + 2 * c];
        if (pix[(2 * r + 1) * DIM + 2 * c + 1] > m) m = pix[(2 * r + 1) * DIM + 2 * c + 1];
        return m;
    endfunction

    task automatic check_frame(input string tag);
        check({tag, "_count"}, got.size(), NOUT);
        for (int k = 0; k < got.size() && k < NOUT; k++) begin
            check($sformatf("%s_out%0d", tag, k), got[k], ref_out(k));
        end
    endtask

    // Called at posedge+1. Pulses start, streams pix[] and sinks outputs until
    // all results and the done pulse are seen (or abort_at inputs accepted).
    task automatic run_frame(input bit vrand, input int stall_at, input int stall_len,
                             input int abort_at, input int mid_start);
        int idx, stall_cnt, cyc;
        bit acc, hs, stalling;
        logic [DW-1:0] hold_val;
        got.delete();
        done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
        idx = 0; stall_cnt = 0; cyc = 0; hold_val = '0;
        while (cyc < BUDGET) begin
            start    = (cyc == 0) || (idx == mid_start);
            in_valid = (idx < NPIX) && (!vrand || ($urandom_range(0, 1) == 1));
            in_data  = (idx < NPIX) ? pix[idx] : '0;
            stalling = out_valid && (got.size() == stall_at) && (stall_cnt < stall_len);
            out_ready = !stalling;
            if (stalling) stall_cnt++;
            @(negedge clk);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (stalling) begin
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                if (stall_cnt == 1) hold_val = out_data;
                else check("stall_out_data", out_data, hold_val);
            end
            if (hs) begin
                got.push_back(out_data);
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
            if (abort_at >= 0 && idx >= abort_at) break;
            if (got.size() >= NOUT && done_cnt > 0) break;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        if (abort_at < 0) begin
            check("frame_in_budget", {31'd0, cyc < BUDGET}, 32'd1);
            check("done_timing", done_cyc, last_hs_cyc + 1);
            check("done_once", done_cnt, 1);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #1;
        // Reset state.
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Inputs offered while idle are refused.
        in_valid = 1'b1; in_data = 20'h00123;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1 in_valid = 1'b0;

        // Ramp frame.
        for (int i = 0; i < NPIX; i++) pix[i] = DW'(i);
        run_frame(1'b0, -1, 0, -1, -1);
        check_frame("ramp");
        check("ramp_first",  got[0],   32'd27);
        check("ramp_second", got[1],   32'd29);
        check("ramp_out13",  got[13],  32'd79);
        check("ramp_last",   got[168], 32'd675);
        @(negedge clk);
        check("ramp_busy_low", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Checkerboard: window max cycles through TL, TR, BL, BR corners.
        for (int y = 0; y < DIM; y++) begin
            for (int x = 0; x < DIM; x++) begin
                int w, pos;
                w   = (y / 2) * (DIM / 2) + (x / 2);
                pos = (y % 2) * 2 + (x % 2);
                pix[y * DIM + x] = (pos == w % 4) ? 20'hFFFFF : 20'h00001;
            end
        end
        run_frame(1'b0, -1, 0, -1, -1);
        check_frame("checker");
        check("checker_out0", got[0], 32'hFFFFF);
        check("checker_out1", got[1], 32'hFFFFF);
        check("checker_out2", got[2], 32'hFFFFF);
        check("checker_out3", got[3], 32'hFFFFF);
        @(posedge clk); #1;

        // Random data, random in_valid, output 7 stalled for 5 cycles.
        for (int i = 0; i < NPIX; i++) pix[i] = DW'($urandom);
        run_frame(1'b1, 7, 5, -1, -1);
        check_frame("random");
        @(posedge clk); #1;

        // All-zero frame with a mid-frame start, then all-ones back-to-back.
        for (int i = 0; i < NPIX; i++) pix[i] = 20'h00000;
        run_frame(1'b0, -1, 0, -1, 100);
        check_frame("zeros");
        check("zeros_busy_low", {31'd0, busy}, 32'd0);
        for (int i = 0; i < NPIX; i++) pix[i] = 20'hFFFFF;
        run_frame(1'b0, -1, 0, -1, -1);
        check_frame("ones");
        check("ones_out0", got[0], 32'hFFFFF);
        @(posedge clk); #1;

        // Reset after 300 accepts.
        for (int i = 0; i < NPIX; i++) pix[i] = DW'(i);
        run_frame(1'b0, -1, 0, 300, -1);
        rst = 1'b0;
        #1;
        check("abort_in_ready",  {31'd0, in_ready},  32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_out_data",  out_data, 32'd0);
        check("abort_busy",      {31'd0, busy},      32'd0);
        check("abort_done",      {31'd0, done},      32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        run_frame(1'b0, -1, 0, -1, -1);
        check_frame("ramp2");
        check("ramp2_first", got[0], 32'd27);
        @(posedge clk); #1;

        // Final output stalled for 3 cycles in DRAIN.
        run_frame(1'b0, 168, 3, -1, -1);
        check_frame("tail_stall");
        check("tail_last", got[168], 32'd675);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pool stage directly downstream of the 3x3 convolution engine.
- Consumes the DIM x DIM convolution result map (default 26x26, 20-bit) in raster order over a valid/ready handshake.
- Emits the (DIM/2) x (DIM/2) pooled map (default 13x13 = 169 values) in raster order.
- Uses a half-row line buffer, so the full conv map is never stored.

Parameters:
- DIM, 26, input map width and height; must be even (DIM >= 2).
- DW, 20, data width of input and output samples; values are compared as unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  one-cycle pulse; arms the block for one frame when IDLE, ignored otherwise.
- in_valid  input  1  upstream sample valid.
- in_data  input  DW  conv result sample, raster order (row 0 col 0 first).
- in_ready  output  1  block accepts in_data this cycle when in_valid && in_ready.
- out_valid  output  1  pooled sample valid.
- out_data  output  DW  pooled maximum.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  high from frame arm until done.
- done  output  1  one-cycle pulse after the final pooled sample is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; col/row counters=0; in_ready=0; out_valid=0; out_data=0; busy=0; done=0. Line buffer contents are don't-care.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start: clear col, row and hold registers; busy=1.
  - RUN -> DRAIN on the accept of the sample at (row=DIM-1, col=DIM-1).
  - DRAIN -> DONE when the last output handshake completes (out_valid && out_ready). If the handshake occurs in the same cycle the last output is produced, DRAIN is still entered for exactly one cycle.
  - DONE -> IDLE unconditionally: done=1 for that one cycle, busy=0 from the next cycle.
- in_ready = (state==RUN) && (!out_valid || out_ready). Combinational from registered state and out_ready only, never from in_valid.
- Counters advance only on an input accept. col wraps DIM-1 -> 0 and increments row. row counts to DIM-1 and is not wrapped within a frame.
- Horizontal pairing:
  - even col: hold <= in_data.
  - odd col: hmax = max(hold, in_data), combinational.
- Vertical pairing, on odd col:
  - even row: linebuf[col>>1] <= hmax.
  - odd row: out_data <= max(linebuf[col>>1], hmax); out_valid <= 1.
- Ties resolve to either operand; the value is identical.
- Latency: out_valid rises the cycle after the accept of the bottom-right pixel of each 2x2 window.
- Output register is single-entry. out_valid clears on out_valid && out_ready unless a new result is loaded in the same cycle; a new result overwrites only when out_ready=1 or out_valid=0, which is guaranteed by in_ready.
- out_data holds stable while out_valid && !out_ready.
- Inputs presented while not in RUN are not accepted (in_ready=0) and are not counted.
- start during RUN, DRAIN or DONE is ignored; no restart mid-frame.
- Reset mid-frame aborts immediately to the reset values above. No done pulse is produced and the partial output is discarded.
- Line buffer: DIM/2 entries x DW bits, one write port and one read port, read address = col>>1. A distributed/register array is acceptable.
- Exactly (DIM/2)^2 out handshakes per frame.

Test Plan:
- Ramp frame with in_data = row*26+col, in_valid=1 and out_ready=1 throughout -> 169 outputs. First output = 27, second = 29, output 13 = 79, last = 675. Then done pulses once and busy falls.
- Checkerboard in which each 2x2 window has its max at a different corner (TL, TR, BL, BR cycling), values 0xFFFFF vs 0x00001 -> every output = 0xFFFFF. Confirms all four corner paths.
- Random data with in_valid toggled randomly and out_ready held 0 for 5 cycles at output 7 -> in_ready=0 while blocked, out_data stable, no lost or duplicated outputs. Results match the reference model.
- All-zero frame followed by an all-0xFFFFF frame back-to-back with start pulsed in DONE+1 -> 169 zeros, then 169 x 0xFFFFF. start pulsed mid-frame is ignored.
- rst=0 asserted after 300 input accepts, then released and start pulsed -> all outputs are at reset values immediately and there is no done pulse. The next full ramp frame produces correct results from output 0.
- Final pixel accepted while out_ready=0 for 3 cycles -> block stays in DRAIN; done pulses exactly one cycle after the 169th handshake.
